ejercicio_5: RTL and testbench



---
 rtl/ejercicio_5.sv | 37 +++
 tb/tb_ejercicio_5.sv | 62 ++++++
 2 files changed

// File: rtl/ejercicio_5.sv
// ejercicio_5: free-running 4-bit counter with hex 7-segment decoder. Ports: clk, reset (sync, active-high), seg {g,f,e,d,c,b,a}, count
module ejercicio_5 #(
  parameter int MAX_COUNT      = 15,
  parameter bit SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] seg,
  output logic [3:0] count
);
  logic [6:0] pat;
  always_ff @(posedge clk)
    count <= (reset || count == 4'(MAX_COUNT)) ? 4'd0 : count + 4'd1;
  always_comb begin
    pat = 7'h00;
    case (count)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
  end
  assign seg = SEG_ACTIVE_LOW ? ~pat : pat;
endmodule

// File: tb/tb_ejercicio_5.sv
// tb_ejercicio_5: checks hex, decade and common-anode variants against an arithmetic reference model
module tb_ejercicio_5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] cnt_a, cnt_b, cnt_c;
  int compared = 0;
  int mismatched = 0;
  int e [3];
  int mx [3] = '{15, 9, 15};
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  always #5 clk = ~clk;
  ejercicio_5 #(.MAX_COUNT(15), .SEG_ACTIVE_LOW(0)) u_a (.clk(clk), .reset(reset), .seg(seg_a), .count(cnt_a));
  ejercicio_5 #(.MAX_COUNT(9),  .SEG_ACTIVE_LOW(0)) u_b (.clk(clk), .reset(reset), .seg(seg_b), .count(cnt_b));
  ejercicio_5 #(.MAX_COUNT(15), .SEG_ACTIVE_LOW(1)) u_c (.clk(clk), .reset(reset), .seg(seg_c), .count(cnt_c));
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r);
    reset = r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) e[i] = r ? 0 : (e[i] + 1) % (mx[i] + 1);
    @(negedge clk);
    chk("count_hex", {3'b0, cnt_a}, 7'(e[0]));
    chk("seg_hex", seg_a, glyph[e[0]]);
    chk("count_dec", {3'b0, cnt_b}, 7'(e[1]));
    chk("seg_dec", seg_b, glyph[e[1]]);
    chk("count_inv", {3'b0, cnt_c}, 7'(e[2]));
    chk("seg_inv", seg_c, ~glyph[e[2]]);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) e[i] = 0;
    step(1'b1);
    chk("reset_seg", seg_a, 7'h3F);
    chk("reset_seg_inv", seg_c, 7'h40);
    step(1'b0);
    chk("first_inc", {3'b0, cnt_a}, 7'd1);
    chk("first_inc_inv", seg_c, 7'h79);
    for (int k = 0; k < 34; k++) step(1'b0);
    step(1'b1);
    for (int k = 0; k < 7; k++) step(1'b0);
    chk("mid_at7", {3'b0, cnt_a}, 7'd7);
    step(1'b1);
    chk("mid_reset", {3'b0, cnt_a}, 7'd0);
    step(1'b0);
    step(1'b0);
    chk("resume", {3'b0, cnt_a}, 7'd2);
    for (int k = 0; k < 300; k++) step(($urandom % 8) == 0);
    step(1'b1);
    for (int k = 0; k < 15; k++) step(1'b0);
    chk("at_max", seg_a, 7'h71);
    step(1'b0);
    chk("wrap_hex", {3'b0, cnt_a}, 7'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
